control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 SHALL provide port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port: reset  input  1  synchronous active-high reset.
REQ-004 SHALL provide port: start  input  1  request to execute op; sampled only in IDLE.
REQ-005 SHALL provide port: op  input  3  operation code (see REQ-013).
REQ-006 SHALL provide port: cnt  input  2  shift repeat count minus one (shift ops only).
REQ-007 SHALL provide port: Tx  output  3  register X command.
REQ-008 SHALL provide port: Ty  output  3  register Y command.
REQ-009 SHALL provide port: Tz  output  3  register Z command.
REQ-010 SHALL provide port: ula  output  2  ALU select: 00 ADD (X+Y), 01 SUB (X-Y).
REQ-011 SHALL provide port: selx  output  1  X input mux: 0 external bus, 1 Z.
REQ-012 SHALL provide ports: busy  output  1  op in progress; done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL decode op: 000 CLR, 001 LDX, 010 LDY, 011 ADD, 100 SUB, 101 SHR, 110 SHL, 111 ACC.
REQ-014 SHALL drive register commands with encoding HOLD 000, LOAD 001, SHIFTR 010, SHIFTL 011, RESET 100.
REQ-015 SHALL implement states IDLE, EXEC, WB, DONE.
REQ-016 SHALL compute all outputs from state, latched op, and latched count only; no combinational input-to-output path.
REQ-017 SHALL, in IDLE, drive Tx=Ty=Tz=HOLD, ula=00, selx=0, busy=0, done=0.
REQ-018 SHALL, when start=1 is sampled in IDLE, latch op and cnt and enter EXEC on the next edge.
REQ-019 SHALL assert busy=1 in EXEC, WB and DONE.
REQ-020 SHALL ignore start outside IDLE; op and cnt changes after latching have no effect.
REQ-021 SHALL, in EXEC, drive: CLR Tx=Ty=Tz=RESET; LDX Tx=LOAD, selx=0; LDY Ty=LOAD; ADD Tz=LOAD, ula=00; SUB Tz=LOAD, ula=01; SHR Tx=SHIFTR; SHL Tx=SHIFTL; ACC Tz=LOAD, ula=00. All unlisted commands are HOLD.
REQ-022 SHALL hold EXEC for exactly 1 cycle for every op except SHR/SHL.
REQ-023 SHALL hold EXEC for SHR/SHL for exactly cnt+1 cycles (1..4) using a 2-bit down-counter loaded with cnt; leave EXEC when the counter equals 0.
REQ-024 SHALL go EXEC->WB for ACC only; all other ops go EXEC->DONE.
REQ-025 SHALL, in WB, drive Tx=LOAD, selx=1, all other commands HOLD, for exactly 1 cycle, then go to DONE.
REQ-026 SHALL, in DONE, drive all commands HOLD, done=1 for exactly 1 cycle, then return to IDLE.
REQ-027 SHALL have latency from start sample to done pulse of 2 cycles (single-cycle ops), cnt+2 (shifts), 3 (ACC).
REQ-028 SHALL accept a new start in the IDLE cycle immediately following DONE; minimum issue interval is one op duration plus 1 cycle.

Reset
REQ-029 SHALL, with reset=1 at a rising edge, enter IDLE, clear the latched op, count and counter, and take priority over start and all transitions.
REQ-030 SHALL, on reset mid-operation (any non-IDLE state), abort with no done pulse; outputs show IDLE values from the following cycle.
REQ-031 SHALL give every output its IDLE value after reset: Tx=Ty=Tz=000, ula=00, selx=0, busy=0, done=0.

Verification
REQ-032 SHALL be verified: start=1, op=001 -> next cycle Tx=001, selx=0, busy=1; following cycle done=1; then IDLE.
REQ-033 SHALL be verified: op=110, cnt=11 -> Tx=011 for exactly 4 consecutive cycles, then done=1; total latency 5.
REQ-034 SHALL be verified: op=111 -> EXEC Tz=001, ula=00; WB Tx=001, selx=1; DONE done=1; latency 3.
REQ-035 SHALL be verified: op=100 -> Tz=001, ula=01 for 1 cycle; start pulses and op changes during busy produce no extra op.
REQ-036 SHALL be verified: reset=1 during the 2nd cycle of an op=101, cnt=11 shift -> next cycle all outputs 0, no done pulse; a subsequent start executes normally.
REQ-037 SHALL be verified: op=000 -> Tx=Ty=Tz=100 for 1 cycle; back-to-back start in the cycle after done is accepted.

Source files
------------

// File: rtl/control_unit.sv
// Sequencer for a three-register datapath: decodes op into X/Y/Z commands, ALU select and X mux.
// Latency start->done 2 (single-cycle), cnt+2 (shifts), 3 (ACC); start is ignored while busy.
module control_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] op,
   input  logic [1:0] cnt,
   output logic [2:0] Tx,
   output logic [2:0] Ty,
   output logic [2:0] Tz,
   output logic [1:0] ula,
   output logic       selx,
   output logic       busy,
   output logic       done
);

   localparam logic [2:0] OP_CLR = 3'b000;
   localparam logic [2:0] OP_LDX = 3'b001;
   localparam logic [2:0] OP_LDY = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_SHR = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_ACC = 3'b111;

   localparam logic [2:0] CMD_HOLD   = 3'b000;
   localparam logic [2:0] CMD_LOAD   = 3'b001;
   localparam logic [2:0] CMD_SHIFTR = 3'b010;
   localparam logic [2:0] CMD_SHIFTL = 3'b011;
   localparam logic [2:0] CMD_RESET  = 3'b100;

   localparam logic [1:0] ULA_ADD = 2'b00;
   localparam logic [1:0] ULA_SUB = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      WB   = 2'b10,
      DONE = 2'b11
   } state_t;

   state_t     state, state_nx;
   logic [2:0] op_q;
   logic [1:0] ctr_q;
   logic       is_shift;

   assign is_shift = (op_q == OP_SHR) || (op_q == OP_SHL);

   // ctr_q holds the latched repeat count and counts down the extra shift cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         op_q  <= 3'b000;
         ctr_q <= 2'b00;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            op_q  <= op;
            ctr_q <= cnt;
         end else if (state == EXEC && is_shift && ctr_q != 2'b00) begin
            ctr_q <= ctr_q - 2'b01;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start) state_nx = EXEC;
         EXEC: begin
            if (is_shift && ctr_q != 2'b00) state_nx = EXEC;
            else if (op_q == OP_ACC)       state_nx = WB;
            else                           state_nx = DONE;
         end
         WB:      state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      Tx   = CMD_HOLD;
      Ty   = CMD_HOLD;
      Tz   = CMD_HOLD;
      ula  = ULA_ADD;
      selx = 1'b0;
      busy = (state != IDLE);
      done = (state == DONE);
      case (state)
         EXEC: begin
            case (op_q)
               OP_CLR: begin
                  Tx = CMD_RESET;
                  Ty = CMD_RESET;
                  Tz = CMD_RESET;
               end
               OP_LDX: Tx = CMD_LOAD;
               OP_LDY: Ty = CMD_LOAD;
               OP_ADD: Tz = CMD_LOAD;
               OP_SUB: begin
                  Tz  = CMD_LOAD;
                  ula = ULA_SUB;
               end
               OP_SHR: Tx = CMD_SHIFTR;
               OP_SHL: Tx = CMD_SHIFTL;
               OP_ACC: Tz = CMD_LOAD;
               default: Tx = CMD_HOLD;
            endcase
         end
         // accumulate write-back: X takes the ALU result held in Z
         WB: begin
            Tx   = CMD_LOAD;
            selx = 1'b1;
         end
         default: Tx = CMD_HOLD;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected per-cycle output vectors are queued at issue
// and compared every cycle on the falling edge; an empty queue means IDLE outputs are expected.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] op;
   logic [1:0] cnt;
   logic [2:0] Tx, Ty, Tz;
   logic [1:0] ula;
   logic       selx, busy, done;

   control_unit dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .cnt   (cnt),
      .Tx    (Tx),
      .Ty    (Ty),
      .Tz    (Tz),
      .ula   (ula),
      .selx  (selx),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   localparam logic [2:0] H = 3'b000, L = 3'b001, SR = 3'b010, SL = 3'b011, RS = 3'b100;
   localparam logic [13:0] IDLE_V = 14'b0;

   logic [13:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic        mon_en = 1'b0;
   string       tag = "reset";

   function automatic logic [13:0] vec(input logic [2:0] tx, input logic [2:0] ty,
                                       input logic [2:0] tz, input logic [1:0] u,
                                       input logic sx, input logic b, input logic d);
      return {tx, ty, tz, u, sx, b, d};
   endfunction

   task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got Tx=%b Ty=%b Tz=%b ula=%b selx=%b busy=%b done=%b, expected Tx=%b Ty=%b Tz=%b ula=%b selx=%b busy=%b done=%b",
                  name, $time, got[13:11], got[10:8], got[7:5], got[4:3], got[2], got[1], got[0],
                  exp[13:11], exp[10:8], exp[7:5], exp[4:3], exp[2], exp[1], exp[0]);
      end
   endtask

   // Reference behaviour: one vector per cycle from the first EXEC cycle through DONE
   task automatic push_expected(input logic [2:0] o, input logic [1:0] c);
      logic [13:0] ex;
      int          n;
      case (o)
         3'd0: ex = vec(RS, RS, RS, 2'b00, 1'b0, 1'b1, 1'b0);
         3'd1: ex = vec(L,  H,  H,  2'b00, 1'b0, 1'b1, 1'b0);
         3'd2: ex = vec(H,  L,  H,  2'b00, 1'b0, 1'b1, 1'b0);
         3'd3: ex = vec(H,  H,  L,  2'b00, 1'b0, 1'b1, 1'b0);
         3'd4: ex = vec(H,  H,  L,  2'b01, 1'b0, 1'b1, 1'b0);
         3'd5: ex = vec(SR, H,  H,  2'b00, 1'b0, 1'b1, 1'b0);
         3'd6: ex = vec(SL, H,  H,  2'b00, 1'b0, 1'b1, 1'b0);
         default: ex = vec(H, H, L, 2'b00, 1'b0, 1'b1, 1'b0);
      endcase
      n = (o == 3'd5 || o == 3'd6) ? int'(c) + 1 : 1;
      for (int i = 0; i < n; i++) exp_q.push_back(ex);
      if (o == 3'd7) exp_q.push_back(vec(L, H, H, 2'b00, 1'b1, 1'b1, 1'b0));
      exp_q.push_back(vec(H, H, H, 2'b00, 1'b0, 1'b1, 1'b1));
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         logic [13:0] e;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
         check(tag, {Tx, Ty, Tz, ula, selx, busy, done}, e);
      end
   end

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() != 0) begin
         check({name, "_timeout"}, 14'(exp_q.size()), 14'd0);
         exp_q.delete();
      end
   endtask

   // Issue one op in the current IDLE cycle; inputs are scrambled after the start cycle
   task automatic run_op(input string name, input logic [2:0] o, input logic [1:0] c,
                         input bit noise);
      @(negedge clk);
      #1;
      tag   = name;
      start = 1'b1;
      op    = o;
      cnt   = c;
      push_expected(o, c);
      @(negedge clk);
      #1;
      start = noise;
      op    = 3'($urandom);
      cnt   = 2'($urandom);
      wait_drain(name);
      #1;
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = 3'b000;
      cnt   = 2'b00;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      @(negedge clk);
      #1;
      reset = 1'b0;

      run_op("ldx", 3'd1, 2'd0, 1'b0);
      run_op("shl_cnt3", 3'd6, 2'd3, 1'b0);
      run_op("acc", 3'd7, 2'd0, 1'b0);
      run_op("sub_busy_start", 3'd4, 2'd0, 1'b1);
      run_op("shr_cnt3_busy_start", 3'd5, 2'd3, 1'b1);

      // reset during the second EXEC cycle of a 4-cycle shift
      @(negedge clk);
      #1;
      tag   = "shr_reset";
      start = 1'b1;
      op    = 3'd5;
      cnt   = 2'd3;
      push_expected(3'd5, 2'd3);
      @(negedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      #1;
      reset = 1'b0;
      tag   = "after_reset_idle";
      repeat (2) @(negedge clk);

      run_op("ldy_after_reset", 3'd2, 2'd0, 1'b0);
      run_op("clr", 3'd0, 2'd0, 1'b0);
      run_op("add_back_to_back", 3'd3, 2'd0, 1'b0);
      run_op("shr_cnt0", 3'd5, 2'd0, 1'b0);
      run_op("shl_cnt1", 3'd6, 2'd1, 1'b0);

      for (int i = 0; i < 16; i++) begin
         run_op("random", 3'($urandom_range(7, 0)), 2'($urandom_range(3, 0)),
                1'($urandom_range(1, 0)));
      end

      tag = "final_idle";
      repeat (3) @(negedge clk);
      #1;
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
